// File: rtl/uart_mmio_fifo.sv
// rtl/uart_mmio_fifo.sv - memory-mapped UART controller with RX/TX byte FIFOs
//
// Decodes EX-stage loads/stores in the BASE_ADDR window and buffers bytes
// between the core and the UART receiver/transmitter.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   instruction           EX-stage instruction (opcode in [6:0])
//   DataB                 store data (rs2)
//   ALU_result            effective address
//   stall                 EX stage held; suppresses register side effects
//   data_out_valid_rx     UART RX byte valid
//   data_out_rx           UART RX byte
//   data_out_ready_rx     RX FIFO can accept a byte
//   data_in_ready_tx      UART TX ready
//   data_in_valid_tx      TX byte valid
//   data_store_tx         TX byte (0 when empty)
//   data_load_formatted   load result for rd
module uart_mmio_fifo #(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] DataB,
  input  logic [31:0] ALU_result,
  input  logic        stall,
  input  logic        data_out_valid_rx,
  input  logic [7:0]  data_out_rx,
  output logic        data_out_ready_rx,
  input  logic        data_in_ready_tx,
  output logic        data_in_valid_tx,
  output logic [7:0]  data_store_tx,
  output logic [31:0] data_load_formatted
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = RX_DEPTH[RX_AW:0];
  localparam logic [TX_AW:0] TX_FULL_CNT = TX_DEPTH[TX_AW:0];

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [RX_AW:0] rx_count;
  logic [TX_AW:0] tx_count;
  logic           rx_underflow, tx_overflow;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic is_load, is_store;
  logic hit_status, hit_rx_data, hit_tx_data, hit_ctrl;
  logic rx_rd_acc, tx_wr_acc, ctrl_acc;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic flush, clear;
  logic [7:0] rx_head;
  logic unused_bits;

  assign unused_bits = ^{instruction[31:7], DataB[31:8]};

  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_head  = rx_mem[rx_rd_ptr];

  assign is_load     = (instruction[6:0] == OPC_LOAD);
  assign is_store    = (instruction[6:0] == OPC_STORE);
  assign hit_status  = (ALU_result == BASE_ADDR);
  assign hit_rx_data = (ALU_result == BASE_ADDR + 32'h4);
  assign hit_tx_data = (ALU_result == BASE_ADDR + 32'h8);
  assign hit_ctrl    = (ALU_result == BASE_ADDR + 32'hC);

  // Qualified accesses: only these may change state.
  assign rx_rd_acc = is_load  && hit_rx_data && !stall;
  assign tx_wr_acc = is_store && hit_tx_data && !stall;
  assign ctrl_acc  = is_store && hit_ctrl    && !stall;
  assign clear     = ctrl_acc && DataB[0];
  assign flush     = ctrl_acc && DataB[1];

  // Handshake outputs are forced low while reset is asserted.
  assign data_out_ready_rx = rst_n && !rx_full;
  assign data_in_valid_tx  = rst_n && !tx_empty;
  assign data_store_tx     = data_in_valid_tx ? tx_mem[tx_rd_ptr] : 8'h00;

  assign rx_push = data_out_valid_rx && data_out_ready_rx;
  assign rx_pop  = rx_rd_acc && !rx_empty;
  // Fullness is judged on pre-edge state, so a concurrent UART pop does not
  // make room for a store in the same cycle.
  assign tx_push = tx_wr_acc && !tx_full;
  assign tx_pop  = data_in_valid_tx && data_in_ready_tx;

  always_comb begin
    data_load_formatted = 32'h0;
    if (is_load) begin
      if (hit_status)
        data_load_formatted = {8'h00, 8'(tx_count), 8'(rx_count), 4'h0,
                               tx_overflow, rx_underflow, !rx_empty, !tx_full};
      else if (hit_rx_data && !rx_empty)
        data_load_formatted = {24'h0, rx_head};
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= data_out_rx;
    if (tx_push) tx_mem[tx_wr_ptr] <= DataB[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else if (flush) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else if (flush) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (rx_rd_acc && rx_empty)  rx_underflow <= 1'b1;
      else if (clear)             rx_underflow <= 1'b0;
      if (tx_wr_acc && tx_full)   tx_overflow  <= 1'b1;
      else if (clear)             tx_overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb/tb_uart_mmio_fifo.sv - directed self-checking bench for uart_mmio_fifo
module tb_uart_mmio_fifo;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] SW   = 32'h0000_2023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] DataB = 32'h0;
  logic [31:0] ALU_result = 32'h0;
  logic        stall = 1'b0;
  logic        data_out_valid_rx = 1'b0;
  logic [7:0]  data_out_rx = 8'h0;
  logic        data_out_ready_rx;
  logic        data_in_ready_tx = 1'b0;
  logic        data_in_valid_tx;
  logic [7:0]  data_store_tx;
  logic [31:0] data_load_formatted;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_mmio_fifo #(.RX_DEPTH(8), .TX_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instruction(instruction),
    .DataB(DataB),
    .ALU_result(ALU_result),
    .stall(stall),
    .data_out_valid_rx(data_out_valid_rx),
    .data_out_rx(data_out_rx),
    .data_out_ready_rx(data_out_ready_rx),
    .data_in_ready_tx(data_in_ready_tx),
    .data_in_valid_tx(data_in_valid_tx),
    .data_store_tx(data_store_tx),
    .data_load_formatted(data_load_formatted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    instruction = 32'h0;
    ALU_result = 32'h0;
    DataB = 32'h0;
    stall = 1'b0;
    data_out_valid_rx = 1'b0;
  endtask

  task automatic ld(input logic [31:0] off);
    idle();
    instruction = LW;
    ALU_result = BASE + off;
  endtask

  task automatic st(input logic [31:0] off, input logic [31:0] val);
    idle();
    instruction = SW;
    ALU_result = BASE + off;
    DataB = val;
  endtask

  // Cross one rising edge and land on the falling edge.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    ld(32'h0);
    #1;
    chk(tag, data_load_formatted, exp);
  endtask

  initial begin
    // Reset held
    nxt(); nxt();
    chk_status("status_in_reset", 32'h1);
    chk("rx_ready_in_reset", {31'h0, data_out_ready_rx}, 32'h0);
    chk("tx_valid_in_reset", {31'h0, data_in_valid_tx}, 32'h0);
    rst_n = 1'b1;
    nxt();
    chk_status("status_after_reset", 32'h1);
    chk("rx_ready_after_reset", {31'h0, data_out_ready_rx}, 32'h1);
    chk("tx_valid_after_reset", {31'h0, data_in_valid_tx}, 32'h0);

    // Fill TX with 9 stores; the 9th overflows
    for (int i = 0; i < 9; i++) begin
      st(32'h8, 32'h41 + i);
      nxt();
    end
    chk_status("status_tx_full", 32'h0008_0008);
    chk("tx_head_full", {24'h0, data_store_tx}, 32'h41);
    idle();
    data_in_ready_tx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("tx_drain_%0d", i), {23'h0, data_in_valid_tx, data_store_tx}, 32'h100 | (32'h41 + i));
      nxt();
    end
    data_in_ready_tx = 1'b0;
    #1;
    chk("tx_drained", {23'h0, data_in_valid_tx, data_store_tx}, 32'h0);
    chk_status("status_after_drain", 32'h9);
    st(32'hC, 32'h1);
    nxt();
    chk_status("status_clear", 32'h1);

    // RX fill
    for (int i = 0; i < 8; i++) begin
      idle();
      data_out_valid_rx = 1'b1;
      data_out_rx = 8'h10 + 8'(i);
      #1;
      chk($sformatf("rx_ready_%0d", i), {31'h0, data_out_ready_rx}, 32'h1);
      nxt();
    end
    idle();
    #1;
    chk("rx_ready_full", {31'h0, data_out_ready_rx}, 32'h0);
    chk_status("status_rx_full", 32'h0000_0803);

    // Pop at full with a byte offered: only the pop happens
    ld(32'h4);
    data_out_valid_rx = 1'b1;
    data_out_rx = 8'h99;
    #1;
    chk("rx_pop_at_full", data_load_formatted, 32'h10);
    nxt();
    idle();
    #1;
    chk("rx_ready_back", {31'h0, data_out_ready_rx}, 32'h1);
    chk_status("status_rx7", 32'h0000_0703);
    idle();
    data_out_valid_rx = 1'b1;
    data_out_rx = 8'h18;
    nxt();
    chk_status("status_rx8", 32'h0000_0803);

    // Stalled load: value returned, no pop
    ld(32'h4);
    stall = 1'b1;
    #1;
    chk("stall_load", data_load_formatted, 32'h11);
    nxt();
    chk_status("status_after_stall", 32'h0000_0803);

    for (int i = 0; i < 8; i++) begin
      ld(32'h4);
      #1;
      chk($sformatf("rx_load_%0d", i), data_load_formatted, 32'h11 + i);
      nxt();
    end
    chk_status("status_rx_empty", 32'h1);
    ld(32'h4);
    #1;
    chk("rx_underflow_load", data_load_formatted, 32'h0);
    nxt();
    chk_status("status_underflow", 32'h5);
    st(32'hC, 32'h1);
    nxt();

    // Empty RX: load plus incoming byte in one cycle
    ld(32'h4);
    data_out_valid_rx = 1'b1;
    data_out_rx = 8'h5A;
    #1;
    chk("rx_empty_load_push", data_load_formatted, 32'h0);
    nxt();
    chk_status("status_underflow_push", 32'h0000_0107);

    // Unmapped address and load from CTRL read 0
    ld(32'h10);
    #1;
    chk("unmapped_load", data_load_formatted, 32'h0);
    ld(32'hC);
    #1;
    chk("ctrl_load", data_load_formatted, 32'h0);

    // TX full plus UART pop plus store: store dropped
    st(32'hC, 32'h3);
    nxt();
    for (int i = 0; i < 8; i++) begin
      st(32'h8, 32'hA0 + i);
      nxt();
    end
    st(32'h8, 32'h88);
    data_in_ready_tx = 1'b1;
    nxt();
    data_in_ready_tx = 1'b0;
    chk_status("status_full_pop_store", 32'h0007_0009);

    // Flush with concurrent RX push
    st(32'hC, 32'h3);
    data_out_valid_rx = 1'b1;
    data_out_rx = 8'h77;
    nxt();
    chk_status("status_flush", 32'h1);
    chk("tx_valid_flush", {31'h0, data_in_valid_tx}, 32'h0);

    // Reset mid TX drain
    for (int i = 0; i < 3; i++) begin
      st(32'h8, 32'h71 + i);
      nxt();
    end
    idle();
    data_in_ready_tx = 1'b1;
    #1;
    chk("drain_first", {24'h0, data_store_tx}, 32'h71);
    nxt();
    #1;
    chk("drain_second", {24'h0, data_store_tx}, 32'h72);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {22'h0, data_out_ready_rx, data_in_valid_tx, data_store_tx}, 32'h0);
    nxt();
    rst_n = 1'b1;
    data_in_ready_tx = 1'b0;
    nxt();
    chk_status("status_after_midreset", 32'h1);
    chk("tx_valid_after_midreset", {31'h0, data_in_valid_tx}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
